// File: rtl/ping_pong_pkg.sv
// Shared constants for the ping-pong button front end:
// player button indices and the per-channel state encoding.
package ping_pong_pkg;

   localparam int BTN_P1L = 0;
   localparam int BTN_P1R = 1;
   localparam int BTN_P2L = 2;
   localparam int BTN_P2R = 3;
   localparam int NUM_BTN = 4;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_DB_PRESS,
      CH_HELD,
      CH_DB_RELEASE
   } ch_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw player inputs and the
// conditioned level/press/step outputs.
interface button_conditioner_if;
   import ping_pong_pkg::*;

   logic [NUM_BTN-1:0] btn_raw;
   logic               enable;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_step;

   modport master (
      output btn_raw, enable,
      input  btn_level, btn_press, btn_step
   );

   modport slave (
      input  btn_raw, enable,
      output btn_level, btn_press, btn_step
   );
endinterface

// File: rtl/button_channel.sv
// One button: synchronizer, debounce FSM and auto-repeat.
// Outputs are registered; enable gating happens in the top.
module button_channel
   import ping_pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_RATE     = 2500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic step
);

   localparam int DW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX =
      (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);

   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_C   = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RR_C   = RW'(REPEAT_RATE);

   logic          sync1;
   logic          pressed;
   ch_state_e     state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [RW-1:0] rcnt_inc;
   logic [RW-1:0] target;
   logic          rep_q, rep_d;
   logic          level_d, press_d, step_d;

   // Two-flop synchronizer; inverts so 1 means the button is down.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         pressed <= 1'b0;
      end else begin
         sync1   <= ~btn_raw;
         pressed <= sync1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CH_IDLE;
         dcnt_q  <= '0;
         rcnt_q  <= '0;
         rep_q   <= 1'b0;
         level   <= 1'b0;
         press   <= 1'b0;
         step    <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         rcnt_q  <= rcnt_d;
         rep_q   <= rep_d;
         level   <= level_d;
         press   <= press_d;
         step    <= step_d;
      end
   end

   // Next state; rcnt restarts after each step, so the first
   // interval uses REPEAT_DELAY and later ones REPEAT_RATE.
   always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      rcnt_d   = rcnt_q;
      rep_d    = rep_q;
      level_d  = level;
      press_d  = 1'b0;
      step_d   = 1'b0;
      rcnt_inc = rcnt_q + RW'(1);
      target   = rep_q ? RR_C : RD_C;
      unique case (state_q)
         CH_IDLE: begin
            level_d = 1'b0;
            if (pressed) begin
               state_d = CH_DB_PRESS;
               dcnt_d  = '0;
            end
         end
         CH_DB_PRESS: begin
            if (!pressed) begin
               state_d = CH_IDLE;
            end else if (dcnt_q == D_LAST) begin
               state_d = CH_HELD;
               rcnt_d  = '0;
               rep_d   = 1'b0;
               level_d = 1'b1;
               press_d = 1'b1;
               step_d  = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         CH_HELD: begin
            if (!pressed) begin
               state_d = CH_DB_RELEASE;
               dcnt_d  = '0;
            end else if (rcnt_inc == target) begin
               step_d = 1'b1;
               rcnt_d = '0;
               rep_d  = 1'b1;
            end else begin
               rcnt_d = rcnt_inc;
            end
         end
         CH_DB_RELEASE: begin
            if (pressed) begin
               state_d = CH_HELD;
               rcnt_d  = '0;
               rep_d   = 1'b0;
            end else if (dcnt_q == D_LAST) begin
               state_d = CH_IDLE;
               level_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = CH_IDLE;
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels plus the shared enable
// gate on the press/step pulses.
module button_conditioner
   import ping_pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_RATE     = 2500000
) (
   input logic                 clk,
   input logic                 reset,
   button_conditioner_if.slave bus
);

   logic [NUM_BTN-1:0] press_q;
   logic [NUM_BTN-1:0] step_q;
   logic [NUM_BTN-1:0] level_q;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (bus.btn_raw[i]),
         .level   (level_q[i]),
         .press   (press_q[i]),
         .step    (step_q[i])
      );
   end

   assign bus.btn_level = level_q;
   assign bus.btn_press = press_q & {NUM_BTN{bus.enable}};
   assign bus.btn_step  = step_q  & {NUM_BTN{bus.enable}};

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed checks of button_conditioner
// against a run-length reference model.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   button_conditioner_if bus ();

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: q1/q2 are the synchronizer delay, run counts
   // consecutive samples that disagree with the level, since
   // counts cycles from the latest (re)entry into holding.
   int q1 [4];
   int q2 [4];
   int lvl [4];
   int run [4];
   int since [4];
   bit mp [4];
   bit ms [4];

   function automatic void model_step();
      for (int c = 0; c < 4; c++) begin
         int p;
         if (reset) begin
            q1[c] = 0; q2[c] = 0; lvl[c] = 0;
            run[c] = 0; since[c] = 0;
            mp[c] = 0; ms[c] = 0;
         end else begin
            p = q2[c];
            q2[c] = q1[c];
            q1[c] = bus.btn_raw[c] ? 0 : 1;
            mp[c] = 0;
            ms[c] = 0;
            if (p != lvl[c]) begin
               run[c]++;
               if (run[c] == D + 1) begin
                  lvl[c] = p;
                  run[c] = 0;
                  if (p == 1) begin
                     mp[c] = 1; ms[c] = 1; since[c] = 0;
                  end
               end
            end else begin
               if (lvl[c] == 1) begin
                  if (run[c] > 0) since[c] = 0;
                  else begin
                     since[c]++;
                     if (since[c] == RD ||
                         (since[c] > RD && (since[c] - RD) % RR == 0))
                        ms[c] = 1;
                  end
               end
               run[c] = 0;
            end
         end
      end
   endfunction

   function automatic logic [3:0] exp_lvl();
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = (lvl[c] == 1);
      return r;
   endfunction

   function automatic logic [3:0] exp_press();
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = mp[c] & bus.enable;
      return r;
   endfunction

   function automatic logic [3:0] exp_step();
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = ms[c] & bus.enable;
      return r;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.btn_raw = 4'hF;
      bus.enable = 1'b1;
      tick();
      tick();
      if ({bus.btn_level, bus.btn_press, bus.btn_step} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=000",
                  {bus.btn_level, bus.btn_press, bus.btn_step});
      end
      total++;
      reset = 1'b0;
   endtask

   task automatic test_single_press();
      int np = 0, ns = 0, pn = -1, sn = -1;
      for (int n = 0; n < 45; n++) begin
         bus.btn_raw = (n < 30) ? 4'hE : 4'hF;
         tick();
         if (bus.btn_level !== exp_lvl()) begin
            bad++;
            $display("FAIL single_level n=%0d got=%b want=%b",
                     n, bus.btn_level, exp_lvl());
         end
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL single_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         if (bus.btn_step !== exp_step()) begin
            bad++;
            $display("FAIL single_step n=%0d got=%b want=%b",
                     n, bus.btn_step, exp_step());
         end
         total += 3;
         if (bus.btn_press[0]) begin np++; if (pn < 0) pn = n; end
         if (bus.btn_step[0]) begin ns++; if (sn < 0) sn = n; end
      end
      if (np !== 1 || pn !== 6) begin
         bad++;
         $display("FAIL single_latency got=%0d@%0d want=1@6", np, pn);
      end
      if (ns !== 7 || sn !== 6) begin
         bad++;
         $display("FAIL single_steps got=%0d@%0d want=7@6", ns, sn);
      end
      total += 2;
   endtask

   task automatic test_glitch();
      int hits = 0;
      for (int n = 0; n < 15; n++) begin
         bus.btn_raw = (n < 3) ? 4'hB : 4'hF;
         tick();
         if (bus.btn_level !== exp_lvl()) begin
            bad++;
            $display("FAIL glitch_level n=%0d got=%b want=%b",
                     n, bus.btn_level, exp_lvl());
         end
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL glitch_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         total += 2;
         if (bus.btn_level[2] || bus.btn_press[2] || bus.btn_step[2])
            hits++;
      end
      if (hits !== 0) begin
         bad++;
         $display("FAIL glitch_activity got=%0d want=0", hits);
      end
      total++;
   endtask

   task automatic test_rebounce();
      int np = 0, drop = 0, sn = -1;
      for (int n = 0; n < 52; n++) begin
         bus.btn_raw = (n < 40 && (n < 20 || n > 21)) ? 4'h7 : 4'hF;
         tick();
         if (bus.btn_level !== exp_lvl()) begin
            bad++;
            $display("FAIL rebounce_level n=%0d got=%b want=%b",
                     n, bus.btn_level, exp_lvl());
         end
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL rebounce_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         if (bus.btn_step !== exp_step()) begin
            bad++;
            $display("FAIL rebounce_step n=%0d got=%b want=%b",
                     n, bus.btn_step, exp_step());
         end
         total += 3;
         if (bus.btn_press[3]) np++;
         if (n >= 6 && n < 40 && !bus.btn_level[3]) drop++;
         if (n >= 20 && sn < 0 && bus.btn_step[3]) sn = n;
      end
      if (np !== 1 || drop !== 0) begin
         bad++;
         $display("FAIL rebounce_hold got=%0d,%0d want=1,0", np, drop);
      end
      if (sn !== 34) begin
         bad++;
         $display("FAIL rebounce_restart got=%0d want=34", sn);
      end
      total += 2;
   endtask

   task automatic test_enable();
      int first [4];
      int np = 0;
      for (int c = 0; c < 4; c++) first[c] = -1;
      for (int n = 0; n < 40; n++) begin
         bus.btn_raw = (n < 25) ? 4'h0 : 4'hF;
         bus.enable = (n >= 14);
         tick();
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL enable_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         if (bus.btn_step !== exp_step()) begin
            bad++;
            $display("FAIL enable_step n=%0d got=%b want=%b",
                     n, bus.btn_step, exp_step());
         end
         total += 2;
         for (int c = 0; c < 4; c++) begin
            if (bus.btn_press[c]) np++;
            if (first[c] < 0 && (bus.btn_step[c] || bus.btn_press[c]))
               first[c] = n;
         end
      end
      bus.enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (first[c] !== 16) begin
            bad++;
            $display("FAIL enable_first bit=%0d got=%0d want=16",
                     c, first[c]);
         end
         total++;
      end
      if (np !== 0) begin
         bad++;
         $display("FAIL enable_dropped got=%0d want=0", np);
      end
      total++;
   endtask

   task automatic test_reset_mid();
      int np = 0, pn = -1;
      for (int n = 0; n < 45; n++) begin
         bus.btn_raw = (n < 30) ? 4'hD : 4'hF;
         reset = (n == 10);
         tick();
         if (bus.btn_level !== exp_lvl()) begin
            bad++;
            $display("FAIL rstmid_level n=%0d got=%b want=%b",
                     n, bus.btn_level, exp_lvl());
         end
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL rstmid_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         total += 2;
         if (n == 10) begin
            if ({bus.btn_level, bus.btn_press, bus.btn_step} !== 12'h0) begin
               bad++;
               $display("FAIL rstmid_clear got=%h want=000",
                        {bus.btn_level, bus.btn_press, bus.btn_step});
            end
            total++;
         end
         if (n > 10 && bus.btn_press[1]) begin
            np++;
            if (pn < 0) pn = n;
         end
      end
      reset = 1'b0;
      if (np !== 1 || pn !== 17) begin
         bad++;
         $display("FAIL rstmid_repress got=%0d@%0d want=1@17", np, pn);
      end
      total++;
   endtask

   task automatic test_random();
      int left [4];
      for (int c = 0; c < 4; c++) left[c] = 0;
      bus.btn_raw = 4'hF;
      for (int n = 0; n < 800; n++) begin
         for (int c = 0; c < 4; c++) begin
            if (left[c] == 0) begin
               bus.btn_raw[c] = ~bus.btn_raw[c];
               left[c] = bus.btn_raw[c] ? $urandom_range(12, 1)
                                        : $urandom_range(25, 1);
            end
            left[c]--;
         end
         bus.enable = ($urandom_range(9, 0) != 0);
         reset = ($urandom_range(199, 0) == 0);
         tick();
         if (bus.btn_level !== exp_lvl()) begin
            bad++;
            $display("FAIL rand_level n=%0d got=%b want=%b",
                     n, bus.btn_level, exp_lvl());
         end
         if (bus.btn_press !== exp_press()) begin
            bad++;
            $display("FAIL rand_press n=%0d got=%b want=%b",
                     n, bus.btn_press, exp_press());
         end
         if (bus.btn_step !== exp_step()) begin
            bad++;
            $display("FAIL rand_step n=%0d got=%b want=%b",
                     n, bus.btn_step, exp_step());
         end
         total += 3;
      end
      reset = 1'b0;
      bus.enable = 1'b1;
   endtask

   initial begin
      bus.btn_raw = 4'hF;
      bus.enable = 1'b1;
      test_reset();
      test_single_press();
      test_glitch();
      test_rebounce();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable cycles required to accept a press or release (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 15000000, cycles from accepted press to first auto-repeat step.
REQ-003 Parameter REPEAT_RATE, default 2500000, cycles between subsequent auto-repeat steps.
REQ-004 clk  input  1  system clock; sole clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  4  raw player buttons, active-low, asynchronous; bit order p1l, p1r, p2l, p2r (bits 0..3).
REQ-007 enable  input  1  when 0, suppresses btn_press and btn_step pulses; FSMs keep running.
REQ-008 btn_level  output  4  debounced button state, active-high, 1 = held.
REQ-009 btn_press  output  4  one-cycle pulse per accepted press.
REQ-010 btn_step  output  4  one-cycle movement pulse: on press, then auto-repeat while held; consumed by board_controller.

Function
REQ-011 Each channel SHALL pass ~btn_raw through a 2-flop synchronizer; the second-stage output "pressed" drives the FSM.
REQ-012 Each channel SHALL implement FSM states IDLE, DB_PRESS, HELD, DB_RELEASE with one debounce counter (dcnt) and one repeat counter (rcnt), each sized to its parameter's maximum.
REQ-013 IDLE: btn_level=0; pressed=1 -> DB_PRESS with dcnt=0.
REQ-014 DB_PRESS: pressed=0 -> IDLE, no pulse; otherwise dcnt increments; dcnt==DEBOUNCE_CYCLES-1 while pressed -> HELD, rcnt=0.
REQ-015 HELD entry SHALL register btn_level=1 and one-cycle btn_press and btn_step, all visible in the cycle after the transition edge.
REQ-016 HELD: rcnt increments each cycle; btn_step pulses when rcnt==REPEAT_DELAY, then every REPEAT_RATE cycles thereafter (entry cycle t0: steps at t0, t0+REPEAT_DELAY, t0+REPEAT_DELAY+REPEAT_RATE, ...); rcnt never wraps into a spurious pulse.
REQ-017 HELD: pressed=0 -> DB_RELEASE with dcnt=0; btn_level remains 1.
REQ-018 DB_RELEASE: pressed=1 -> HELD with rcnt=0, no btn_press, no btn_step; dcnt==DEBOUNCE_CYCLES-1 while released -> IDLE with btn_level=0.
REQ-019 Press latency: raw assertion sampled at edge k -> btn_press high in the cycle after edge k+2+DEBOUNCE_CYCLES.
REQ-020 enable=0 SHALL force btn_press and btn_step to 0 without altering state or counters; pulses due while disabled are dropped, not deferred.
REQ-021 Channels SHALL be fully independent; simultaneous presses on any subset SHALL produce simultaneous, independent pulses.
REQ-022 DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE SHALL each be >=1; DEBOUNCE_CYCLES=1 means one stable cycle in DB_PRESS.

Reset
REQ-023 reset=1 SHALL on the next edge set all FSMs to IDLE, clear all counters, set synchronizer flops to "released", and drive all outputs to 0.
REQ-024 Reset asserted mid-operation SHALL abort in-progress debounce or repeat with no pulse generated.
REQ-025 A button held through reset deassertion SHALL be re-debounced and produce exactly one btn_press per REQ-019.

Structure
REQ-026 Shared package ping_pong_pkg SHALL hold button index constants BTN_P1L=0, BTN_P1R=1, BTN_P2L=2, BTN_P2R=3 and the channel state encoding.
REQ-027 Per-channel logic SHALL live in sub-module button_channel, instantiated four times; the top holds only instantiation and enable gating.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-028 btn_raw[0] low from edge 5, held 30 cycles -> btn_press[0] pulses once in the cycle after edge 11; btn_step[0] at t0, t0+10, t0+13, t0+16, ...; other bits stay 0.
REQ-029 btn_raw[2] low for 3 cycles, then high -> no btn_press, btn_step or btn_level change.
REQ-030 Held button released 2 cycles, then pressed again -> btn_level stays 1, no new btn_press, repeat restarts with next step 10 cycles after re-entry.
REQ-031 All four buttons pressed on the same edge with enable=0 for the first 8 cycles of HELD -> no pulses in that window; first pulse on each bit at t0+10.
REQ-032 reset=1 for 1 cycle during HELD of bit 1 with the button still held -> outputs 0 the next cycle, then exactly one btn_press[1] 2+4 cycles after reset deasserts.
